// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory access controller
package mem_ctrl_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_A     = 4'd1,
        WAIT_A   = 4'd2,
        RD_B     = 4'd3,
        WAIT_B   = 4'd4,
        EXEC     = 4'd5,
        WAIT_RES = 4'd6,
        WR       = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam logic REGION_0 = 1'b0;
    localparam logic REGION_1 = 1'b1;

    // Word accesses need even byte addresses.
    function automatic logic is_odd(input word_t a);
        return a[0];
    endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// rtl/ctrl_wait_counter.sv - loadable down-counter with zero flag
module ctrl_wait_counter
    import mem_ctrl_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  word_t i_load_val,
    input  logic  i_dec,
    output logic  o_zero
);

    word_t r_count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_zero = (r_count == 16'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - fetch two operands, hand them off, write back the result
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  word_t addr_a,
    input  word_t addr_b,
    input  word_t addr_r,
    input  logic  region,
    output logic  busy,
    output logic  done,
    output logic  err,
    output word_t op_a,
    output word_t op_b,
    output logic  op_valid,
    input  logic  op_ready,
    input  word_t res,
    input  logic  res_valid,
    output logic  mem_e,
    output logic  mem_we,
    output logic  mem_data,
    output word_t mem_addr,
    output word_t mem_wdata,
    input  word_t mem_rdata
);

    // The counter holds "remaining cycles minus one" so zero marks the last cycle.
    localparam word_t LAT_LOAD = word_t'(READ_LAT - 1);
    localparam word_t TMO_LOAD = word_t'(TIMEOUT - 1);

    state_t r_state;
    state_t w_next;
    word_t  r_addr_a;
    word_t  r_addr_b;
    word_t  r_addr_r;
    word_t  r_res;
    logic   r_region;

    logic   w_accept;
    logic   w_bad_addr;
    logic   w_cap_a;
    logic   w_cap_b;
    logic   w_cap_res;
    logic   w_timeout;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_zero;
    word_t  w_cnt_val;

    ctrl_wait_counter u_wait_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and memory/handshake outputs.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_bad_addr = 1'b0;
        w_cap_a    = 1'b0;
        w_cap_b    = 1'b0;
        w_cap_res  = 1'b0;
        w_timeout  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_cnt_val  = LAT_LOAD;
        mem_e      = 1'b0;
        mem_we     = 1'b0;
        mem_data   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        op_valid   = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (is_odd(addr_a) || is_odd(addr_b) || is_odd(addr_r)) begin
                        w_bad_addr = 1'b1;
                        w_next     = DONE;
                    end else begin
                        w_next = RD_A;
                    end
                end
            end
            RD_A: begin
                mem_e      = 1'b1;
                mem_addr   = r_addr_a;
                mem_data   = r_region;
                w_cnt_load = 1'b1;
                w_next     = WAIT_A;
            end
            WAIT_A: begin
                if (w_cnt_zero) begin
                    w_cap_a = 1'b1;
                    w_next  = RD_B;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            RD_B: begin
                mem_e      = 1'b1;
                mem_addr   = r_addr_b;
                mem_data   = r_region;
                w_cnt_load = 1'b1;
                w_next     = WAIT_B;
            end
            WAIT_B: begin
                if (w_cnt_zero) begin
                    w_cap_b = 1'b1;
                    w_next  = EXEC;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            EXEC: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = TMO_LOAD;
                    w_next     = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    w_cap_res = 1'b1;
                    w_next    = WR;
                end else if (w_cnt_zero) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            WR: begin
                mem_e     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr_r;
                mem_wdata = r_res;
                mem_data  = r_region;
                w_next    = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busy = (r_state != IDLE);

    // Request latch, operand/result capture and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_r <= '0;
            r_region <= REGION_0;
            r_res    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr_a <= addr_a;
                r_addr_b <= addr_b;
                r_addr_r <= addr_r;
                r_region <= region;
                err      <= w_bad_addr;
            end
            if (w_timeout) begin
                err <= 1'b1;
            end
            if (w_cap_a) begin
                op_a <= mem_rdata;
            end
            if (w_cap_b) begin
                op_b <= mem_rdata;
            end
            if (w_cap_res) begin
                r_res <= res;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mem_init;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [15:0] init_word(input int i);
        if (i == 2) return 16'h1111;
        if (i == 3) return 16'h2222;
        return 16'(i * 256 + 5);
    endfunction

    // ---------------- instance 1: READ_LAT=1, TIMEOUT=4 ----------------
    logic        start1, region1, busy1, done1, err1, op_valid1, op_ready1, res_valid1;
    logic        mem_e1, mem_we1, mem_data1;
    logic [15:0] addr_a1, addr_b1, addr_r1, op_a1, op_b1, res1, mem_addr1, mem_wdata1, mem_rdata1;

    mem_access_ctrl #(.READ_LAT(1), .TIMEOUT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .addr_a(addr_a1), .addr_b(addr_b1), .addr_r(addr_r1), .region(region1),
        .busy(busy1), .done(done1), .err(err1), .op_a(op_a1), .op_b(op_b1),
        .op_valid(op_valid1), .op_ready(op_ready1), .res(res1), .res_valid(res_valid1),
        .mem_e(mem_e1), .mem_we(mem_we1), .mem_data(mem_data1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    logic [15:0] mem1 [16];
    logic [15:0] dq1;
    logic        dv1 = 1'b0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem1[i] <= init_word(i);
        end else if (mem_e1 && mem_we1) begin
            mem1[mem_addr1[4:1]] <= mem_wdata1;
        end
        dv1 <= mem_e1 && !mem_we1;
        dq1 <= mem1[mem_addr1[4:1]];
    end
    assign mem_rdata1 = dv1 ? dq1 : 16'hDEAD;

    logic hs1 = 1'b0;
    logic res_en1;
    int   dly1, ovc1 = 0;
    always @(posedge clk) hs1 <= op_valid1 && op_ready1;
    always @(posedge clk) ovc1 <= op_valid1 ? ovc1 + 1 : 0;
    assign op_ready1  = (ovc1 >= dly1);
    assign res_valid1 = hs1 && res_en1;
    assign res1       = op_a1 + op_b1;

    int          me_cnt1 = 0, wr_cnt1 = 0, rb_cnt1 = 0, ib_cnt1 = 0, dn_cnt1 = 0;
    logic [15:0] last_waddr1 = '0, last_wdata1 = '0;
    logic        cur_region1 = 1'b0;
    always @(negedge clk) begin
        if (mem_e1) begin
            me_cnt1 <= me_cnt1 + 1;
            if (mem_data1 !== cur_region1) rb_cnt1 <= rb_cnt1 + 1;
            if (mem_we1) begin
                wr_cnt1     <= wr_cnt1 + 1;
                last_waddr1 <= mem_addr1;
                last_wdata1 <= mem_wdata1;
            end
        end else if (mem_addr1 !== 16'h0 || mem_wdata1 !== 16'h0 || mem_we1 !== 1'b0) begin
            ib_cnt1 <= ib_cnt1 + 1;
        end
        if (done1) dn_cnt1 <= dn_cnt1 + 1;
    end

    // ---------------- instance 3: READ_LAT=3, TIMEOUT=255 ----------------
    logic        start3, region3, busy3, done3, err3, op_valid3, op_ready3, res_valid3;
    logic        mem_e3, mem_we3, mem_data3;
    logic [15:0] addr_a3, addr_b3, addr_r3, op_a3, op_b3, res3, mem_addr3, mem_wdata3, mem_rdata3;

    mem_access_ctrl #(.READ_LAT(3), .TIMEOUT(255)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .addr_a(addr_a3), .addr_b(addr_b3), .addr_r(addr_r3), .region(region3),
        .busy(busy3), .done(done3), .err(err3), .op_a(op_a3), .op_b(op_b3),
        .op_valid(op_valid3), .op_ready(op_ready3), .res(res3), .res_valid(res_valid3),
        .mem_e(mem_e3), .mem_we(mem_we3), .mem_data(mem_data3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    logic [15:0] mem3 [16];
    logic [15:0] dq3 [3];
    logic [2:0]  dv3 = '0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem3[i] <= init_word(i);
        end else if (mem_e3 && mem_we3) begin
            mem3[mem_addr3[4:1]] <= mem_wdata3;
        end
        dv3    <= {dv3[1:0], mem_e3 && !mem_we3};
        dq3[0] <= mem3[mem_addr3[4:1]];
        dq3[1] <= dq3[0];
        dq3[2] <= dq3[1];
    end
    assign mem_rdata3 = dv3[2] ? dq3[2] : 16'hDEAD;

    logic hs3 = 1'b0;
    int   dly3, ovc3 = 0;
    always @(posedge clk) hs3 <= op_valid3 && op_ready3;
    always @(posedge clk) ovc3 <= op_valid3 ? ovc3 + 1 : 0;
    assign op_ready3  = (ovc3 >= dly3);
    assign res_valid3 = hs3;
    assign res3       = op_a3 + op_b3;

    int          ov_cnt3 = 0, ovbad3 = 0, rb_cnt3 = 0;
    logic        pv3 = 1'b0;
    logic [15:0] pa3 = '0, pb3 = '0;
    always @(negedge clk) begin
        if (op_valid3) ov_cnt3 <= ov_cnt3 + 1;
        if (op_valid3 && pv3 && (op_a3 !== pa3 || op_b3 !== pb3)) ovbad3 <= ovbad3 + 1;
        if (mem_e3 && mem_data3 !== region3) rb_cnt3 <= rb_cnt3 + 1;
        pv3 <= op_valid3;
        pa3 <= op_a3;
        pb3 <= op_b3;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [15:0] a, b, r;
        logic        region;
        logic        res_en;
        int          dly;
        logic        hold;
    } vec_t;

    typedef struct {
        logic        err;
        logic [15:0] oa, ob, wdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] shadow [16];
    vec_t        vecs [7];

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        logic bad;
        int   n, wr0, me0, rb0, dn0;
        bad     = v.a[0] | v.b[0] | v.r[0];
        e.err   = bad || !v.res_en;
        e.oa    = shadow[v.a[4:1]];
        e.ob    = shadow[v.b[4:1]];
        e.wdata = e.oa + e.ob;
        e.cyc   = bad ? 1 : (v.res_en ? 8 + v.dly : 10 + v.dly);
        if (!e.err) shadow[v.r[4:1]] = e.wdata;
        sb.push_back(e);
        wr0 = wr_cnt1; me0 = me_cnt1; rb0 = rb_cnt1; dn0 = dn_cnt1;
        addr_a1 = v.a; addr_b1 = v.b; addr_r1 = v.r; region1 = v.region;
        cur_region1 = v.region; res_en1 = v.res_en; dly1 = v.dly;
        start1 = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(negedge clk); #1;
            n++;
            if (!v.hold) start1 = 1'b0;
            if (done1) break;
        end
        e = sb.pop_front();
        check({tag, "_done_cycle"}, n, e.cyc);
        check({tag, "_err"}, err1, e.err);
        if (!e.err) begin
            check({tag, "_op_a"}, op_a1, e.oa);
            check({tag, "_op_b"}, op_b1, e.ob);
            check({tag, "_waddr"}, last_waddr1, v.r);
            check({tag, "_wdata"}, last_wdata1, e.wdata);
            check({tag, "_mem_word"}, mem1[v.r[4:1]], e.wdata);
        end
        @(negedge clk); #1;
        check({tag, "_busy_after"}, busy1, 1'b0);
        start1 = 1'b0;
        @(negedge clk); #1;
        check({tag, "_idle_stays"}, busy1, 1'b0);
        check({tag, "_writes"}, wr_cnt1 - wr0, e.err ? 0 : 1);
        check({tag, "_mem_e_cycles"}, me_cnt1 - me0, bad ? 0 : (e.err ? 2 : 3));
        check({tag, "_region_bad"}, rb_cnt1 - rb0, 0);
        check({tag, "_done_pulses"}, dn_cnt1 - dn0, 1);
    endtask

    initial begin
        int n, wr0, dn0;
        exp_t e;
        vecs[0] = '{16'd4,  16'd6, 16'd8,  1'b0, 1'b1, 0, 1'b0};
        vecs[1] = '{16'd4,  16'd5, 16'd8,  1'b0, 1'b1, 0, 1'b0};
        vecs[2] = '{16'd8,  16'd4, 16'd12, 1'b0, 1'b0, 0, 1'b0};
        vecs[3] = '{16'd8,  16'd6, 16'd14, 1'b1, 1'b1, 2, 1'b1};
        vecs[4] = '{16'd3,  16'd4, 16'd8,  1'b0, 1'b1, 0, 1'b0};
        vecs[5] = '{16'd2,  16'd4, 16'd9,  1'b1, 1'b1, 0, 1'b0};
        vecs[6] = '{16'd14, 16'd8, 16'd0,  1'b0, 1'b1, 1, 1'b0};

        rst = 1'b1; mem_init = 1'b1;
        start1 = 0; addr_a1 = 0; addr_b1 = 0; addr_r1 = 0; region1 = 0; res_en1 = 1; dly1 = 0;
        start3 = 0; addr_a3 = 0; addr_b3 = 0; addr_r3 = 0; region3 = 0; dly3 = 0;
        for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", busy1, 1'b0);
        check("reset_done", done1, 1'b0);
        check("reset_err", err1, 1'b0);
        check("reset_op_valid", op_valid1, 1'b0);
        check("reset_mem_e", mem_e1, 1'b0);
        check("reset_op_a", op_a1, 16'h0);
        check("reset_busy3", busy3, 1'b0);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during WAIT_B aborts with no write and no done.
        wr0 = wr_cnt1; dn0 = dn_cnt1;
        addr_a1 = 16'd4; addr_b1 = 16'd6; addr_r1 = 16'd10; region1 = 0; cur_region1 = 0; dly1 = 0;
        start1 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            start1 = 1'b0;
        end
        check("rst_pre_busy", busy1, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_busy", busy1, 1'b0);
        check("rst_mem_e", mem_e1, 1'b0);
        check("rst_op_a", op_a1, 16'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("rst_no_write", wr_cnt1 - wr0, 0);
        check("rst_no_done", dn_cnt1 - dn0, 0);
        run_vec(vecs[0], "after_rst");

        // READ_LAT=3 with op_ready held off for 5 cycles.
        e.err = 1'b0; e.oa = 16'h1111; e.ob = 16'h2222; e.wdata = 16'h3333; e.cyc = 8 + 2 * 2 + 5;
        sb.push_back(e);
        addr_a3 = 16'd4; addr_b3 = 16'd6; addr_r3 = 16'd10; region3 = 0; dly3 = 5;
        start3 = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(negedge clk); #1;
            n++;
            start3 = 1'b0;
            if (done3) break;
        end
        e = sb.pop_front();
        check("lat3_done_cycle", n, e.cyc);
        check("lat3_err", err3, e.err);
        check("lat3_op_a", op_a3, e.oa);
        check("lat3_op_b", op_b3, e.ob);
        check("lat3_op_valid_cycles", ov_cnt3, 6);
        check("lat3_op_stable", ovbad3, 0);
        check("lat3_region_bad", rb_cnt3, 0);
        @(negedge clk); #1;
        check("lat3_mem_word", mem3[5], e.wdata);
        check("lat3_busy_after", busy3, 1'b0);

        check("idle_bus_quiet", ib_cnt1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
